// File: rtl/rc5_round_ctrl.sv
// rc5_round_ctrl: sequences RC5-16/12/16 key expansion and encrypt/decrypt rounds for the datapath
module rc5_round_ctrl #(
  parameter int ROUNDS    = 12,
  parameter int KEY_WORDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic       encrypt,
  input  logic       decrypt,
  output logic       ready,
  output logic       busy,
  output logic       key_valid,
  output logic       done,
  output logic       illegal_req,
  output logic       ks_init,
  output logic       ks_mix,
  output logic [4:0] s_addr,
  output logic [2:0] l_addr,
  output logic       pre_whiten,
  output logic       post_whiten,
  output logic       rnd_en,
  output logic       rnd_dir,
  output logic [3:0] rnd_idx
);
  localparam int T  = 2 * ROUNDS + 2;
  localparam int M  = 3 * (T > KEY_WORDS ? T : KEY_WORDS);
  localparam int CW = $clog2(M);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KS_INIT  = 3'd1;
  localparam logic [2:0] KS_MIX   = 3'd2;
  localparam logic [2:0] ENC_PRE  = 3'd3;
  localparam logic [2:0] ENC_RND  = 3'd4;
  localparam logic [2:0] DEC_RND  = 3'd5;
  localparam logic [2:0] DEC_POST = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;
  logic [2:0]    state;
  logic [CW-1:0] k;
  logic [4:0]    s_ctr;
  logic [2:0]    l_ctr;
  logic [3:0]    rnd;
  logic          kv;
  logic          ill;
  // counters are kept at zero outside their states, so outputs need no extra gating
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      s_ctr <= '0;
      l_ctr <= '0;
      rnd   <= '0;
      kv    <= 1'b0;
      ill   <= 1'b0;
    end else begin
      ill <= 1'b0;
      case (state)
        IDLE:
          if (key_load) begin
            state <= KS_INIT;
            kv    <= 1'b0;
          end else if ((encrypt | decrypt) & ((encrypt & decrypt) | ~kv)) ill <= 1'b1;
          else if (encrypt) state <= ENC_PRE;
          else if (decrypt) begin
            state <= DEC_RND;
            rnd   <= 4'(ROUNDS);
          end
        KS_INIT:
          if (s_ctr == 5'(T - 1)) begin
            state <= KS_MIX;
            s_ctr <= '0;
          end else s_ctr <= s_ctr + 5'd1;
        KS_MIX: begin
          s_ctr <= (s_ctr == 5'(T - 1)) ? '0 : s_ctr + 5'd1;
          l_ctr <= (l_ctr == 3'(KEY_WORDS - 1)) ? '0 : l_ctr + 3'd1;
          k     <= k + 1'b1;
          if (k == CW'(M - 1)) begin
            state <= IDLE;
            kv    <= 1'b1;
            k     <= '0;
            s_ctr <= '0;
            l_ctr <= '0;
          end
        end
        ENC_PRE: begin
          state <= ENC_RND;
          rnd   <= 4'd1;
        end
        ENC_RND:
          if (rnd == 4'(ROUNDS)) begin
            state <= DONE;
            rnd   <= '0;
          end else rnd <= rnd + 4'd1;
        DEC_RND:
          if (rnd == 4'd1) begin
            state <= DEC_POST;
            rnd   <= '0;
          end else rnd <= rnd - 4'd1;
        DEC_POST: state <= DONE;
        default:  state <= IDLE;
      endcase
    end
  end
  assign ready       = state == IDLE;
  assign busy        = ~ready;
  assign key_valid   = kv;
  assign done        = state == DONE;
  assign illegal_req = ill;
  assign ks_init     = state == KS_INIT;
  assign ks_mix      = state == KS_MIX;
  assign s_addr      = (ks_init | ks_mix) ? s_ctr : {rnd, 1'b0};
  assign l_addr      = l_ctr;
  assign pre_whiten  = state == ENC_PRE;
  assign post_whiten = state == DEC_POST;
  assign rnd_en      = (state == ENC_RND) | (state == DEC_RND);
  assign rnd_dir     = state == DEC_RND;
  assign rnd_idx     = rnd;
endmodule

// File: tb/tb_rc5_round_ctrl.sv
// tb_rc5_round_ctrl: operation-level model checked every cycle, plus directed literal checks
module tb_rc5_round_ctrl;
  localparam int R  = 12;
  localparam int KW = 8;
  localparam int T  = 2 * R + 2;
  localparam int M  = 3 * T;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_load = 1'b0, encrypt = 1'b0, decrypt = 1'b0;
  logic ready, busy, key_valid, done, illegal_req, ks_init, ks_mix;
  logic [4:0] s_addr;
  logic [2:0] l_addr;
  logic pre_whiten, post_whiten, rnd_en, rnd_dir;
  logic [3:0] rnd_idx;
  int n_run = 0, n_fail = 0;
  int mk = 0, mt = 0;
  bit mkv = 0, mill = 0, armed = 0;

  rc5_round_ctrl #(.ROUNDS(R), .KEY_WORDS(KW)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .encrypt(encrypt), .decrypt(decrypt),
    .ready(ready), .busy(busy), .key_valid(key_valid), .done(done), .illegal_req(illegal_req),
    .ks_init(ks_init), .ks_mix(ks_mix), .s_addr(s_addr), .l_addr(l_addr),
    .pre_whiten(pre_whiten), .post_whiten(post_whiten), .rnd_en(rnd_en),
    .rnd_dir(rnd_dir), .rnd_idx(rnd_idx)
  );

  always #5 clk = ~clk;

  // model: mk = 0 idle, 1 key expansion, 2 encrypt, 3 decrypt; mt = cycles since request edge
  task automatic model_next();
    if (rst) begin
      mk = 0; mt = 0; mkv = 0; mill = 0; armed = 1;
    end else begin
      mill = 0;
      if (mk == 0) begin
        if (key_load) begin mk = 1; mt = 1; mkv = 0; end
        else if (encrypt && decrypt) mill = 1;
        else if ((encrypt || decrypt) && !mkv) mill = 1;
        else if (encrypt) begin mk = 2; mt = 1; end
        else if (decrypt) begin mk = 3; mt = 1; end
      end else if (mt == (mk == 1 ? T + M : R + 2)) begin
        if (mk == 1) mkv = 1;
        mk = 0; mt = 0;
      end else mt++;
    end
  endtask

  function automatic logic [21:0] model_out();
    logic [4:0] s; logic [2:0] l; logic [3:0] idx;
    logic ksi, ksm, pre, post, en, dir, dn;
    int kk;
    s = 0; l = 0; idx = 0; ksi = 0; ksm = 0; pre = 0; post = 0; en = 0; dir = 0; dn = 0;
    if (mk == 1) begin
      if (mt <= T) begin ksi = 1; s = 5'(mt - 1); end
      else begin kk = mt - T - 1; ksm = 1; s = 5'(kk % T); l = 3'(kk % KW); end
    end else if (mk == 2) begin
      if (mt == 1) pre = 1;
      else if (mt <= R + 1) begin en = 1; idx = 4'(mt - 1); s = 5'(2 * (mt - 1)); end
      else dn = 1;
    end else if (mk == 3) begin
      if (mt <= R) begin en = 1; dir = 1; idx = 4'(R + 1 - mt); s = 5'(2 * (R + 1 - mt)); end
      else if (mt == R + 1) post = 1;
      else dn = 1;
    end
    return {mk == 0, mk != 0, mkv, dn, mill, ksi, ksm, s, l, pre, post, en, dir, idx};
  endfunction

  task automatic tick();
    logic [21:0] act, exp;
    model_next();
    @(posedge clk);
    #1;
    if (armed) begin
      act = {ready, busy, key_valid, done, illegal_req, ks_init, ks_mix, s_addr, l_addr,
             pre_whiten, post_whiten, rnd_en, rnd_dir, rnd_idx};
      exp = model_out();
      n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model t=%0t got=%h expected=%h", $time, act, exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  initial begin
    int kvn, dn, cnt;
    int d[3];
    encrypt = 1'b1;
    tick(); tick();
    rst = 1'b0; encrypt = 1'b0;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_done", 32'(done), 0);
    tick(); tick();
    chk("idle_stays", 32'(busy), 0);
    // key expansion
    key_load = 1'b1; kvn = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      key_load = 1'b0;
      if (n == 1) chk("ks_first", {ks_init, 3'b0, s_addr}, {1'b1, 3'b0, 5'd0});
      if (n == 26) chk("ks_init_last", {ks_init, 3'b0, s_addr}, {1'b1, 3'b0, 5'd25});
      if (n == 27) chk("ks_mix_first", {ks_mix, s_addr, l_addr}, {1'b1, 5'd0, 3'd0});
      if (n == 53) chk("ks_mix_k26", {ks_mix, s_addr, l_addr}, {1'b1, 5'd0, 3'd2});
      if (n == 79) chk("ks_mix_k52", {ks_mix, s_addr, l_addr}, {1'b1, 5'd0, 3'd4});
      if (n == 104) chk("ks_mix_k77", {ks_mix, s_addr, l_addr}, {1'b1, 5'd25, 3'd5});
      if (key_valid) begin kvn = n; break; end
    end
    chk("key_valid_cycle", 32'(kvn), 105);
    chk("key_ready", 32'(ready), 1);
    // encrypt, with an ignored key_load mid-rounds
    encrypt = 1'b1; dn = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      encrypt = 1'b0;
      if (n == 1) chk("enc_pre", 32'(pre_whiten), 1);
      if (n == 2) chk("enc_rnd1", {rnd_en, rnd_dir, rnd_idx, s_addr}, {1'b1, 1'b0, 4'd1, 5'd2});
      if (n == 6) chk("enc_keyload_ignored", {illegal_req, busy, key_valid, rnd_idx},
                      {1'b0, 1'b1, 1'b1, 4'd5});
      if (n == 13) chk("enc_rnd12", {rnd_en, rnd_idx, s_addr}, {1'b1, 4'd12, 5'd24});
      key_load = (n == 5);
      if (done) begin dn = n; break; end
    end
    chk("enc_done_cycle", 32'(dn), 14);
    tick();
    chk("enc_ready15", 32'(ready), 1);
    // decrypt
    decrypt = 1'b1; dn = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      decrypt = 1'b0;
      if (n == 1) chk("dec_rnd12", {rnd_en, rnd_dir, rnd_idx, s_addr}, {1'b1, 1'b1, 4'd12, 5'd24});
      if (n == 12) chk("dec_rnd1", {rnd_dir, rnd_idx, s_addr}, {1'b1, 4'd1, 5'd2});
      if (n == 13) chk("dec_post", 32'(post_whiten), 1);
      if (done) begin dn = n; break; end
    end
    chk("dec_done_cycle", 32'(dn), 14);
    tick();
    // continuous decrypt requests
    decrypt = 1'b1; cnt = 0; d = '{0, 0, 0};
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        d[cnt] = n; cnt++;
        if (cnt == 3) begin decrypt = 1'b0; break; end
      end
    end
    chk("b2b_first_done", 32'(d[0]), 14);
    chk("b2b_period1", 32'(d[1] - d[0]), 15);
    chk("b2b_period2", 32'(d[2] - d[1]), 15);
    tick(); tick();
    // both requests at once
    encrypt = 1'b1; decrypt = 1'b1;
    tick();
    encrypt = 1'b0; decrypt = 1'b0;
    chk("illegal_both", {illegal_req, ready}, {1'b1, 1'b1});
    tick();
    chk("illegal_one_cycle", {illegal_req, ready}, {1'b0, 1'b1});
    // key_load wins over encrypt, then reset mid expansion
    key_load = 1'b1; encrypt = 1'b1;
    tick();
    key_load = 1'b0; encrypt = 1'b0;
    chk("keyload_wins", {ks_init, pre_whiten, key_valid}, {1'b1, 1'b0, 1'b0});
    for (int n = 2; n <= 67; n++) tick();
    chk("ks_mix_k40", {ks_mix, s_addr, l_addr}, {1'b1, 5'd14, 3'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", {ready, key_valid, ks_mix}, {1'b1, 1'b0, 1'b0});
    encrypt = 1'b1;
    tick();
    encrypt = 1'b0;
    chk("enc_no_key", {illegal_req, ready}, {1'b1, 1'b1});
    tick();
    chk("enc_no_key_after", {illegal_req, ready}, {1'b0, 1'b1});
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rc5_round_ctrl.md
# rc5_round_ctrl

Sequencing controller for the RC5-16/12/16 accelerator datapath (16-bit words, 32-bit block, 128-bit key). It runs key expansion to fill the S-table, then steps encrypt or decrypt operations through pre-whitening, the rounds and post-whitening. It drives only control, address and index signals; the S-table, L-array and A/B arithmetic are in the datapath. It sits between the top-level encrypt/decrypt request inputs and that datapath.

## Interface
- ROUNDS, 12, round count r; T = 2*ROUNDS+2 S-words (26)
- KEY_WORDS, 8, key length c in 16-bit words
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  request key expansion; sampled only in IDLE
- encrypt  in  1  request one block encryption; sampled only in IDLE
- decrypt  in  1  request one block decryption; sampled only in IDLE
- ready  out  1  state == IDLE
- busy  out  1  ~ready
- key_valid  out  1  S-table holds an expanded key
- done  out  1  one-cycle pulse when an encrypt/decrypt completes
- illegal_req  out  1  one-cycle pulse on a rejected request
- ks_init  out  1  datapath writes S[s_addr] = Pw + s_addr*Qw
- ks_mix  out  1  datapath performs one mix step on S[s_addr], L[l_addr]
- s_addr  out  5  S-table index; in rounds, the even index 2i (datapath also uses 2i+1)
- l_addr  out  3  L-array index
- pre_whiten  out  1  A += S[0], B += S[1]
- post_whiten  out  1  B -= S[1], A -= S[0]
- rnd_en  out  1  perform one round this cycle
- rnd_dir  out  1  0 = encrypt round, 1 = decrypt round
- rnd_idx  out  4  current round number, 1..ROUNDS

## Operation
- Moore machine. All outputs decode from the registered state and counters only. No combinational path from an input to an output.
- States: IDLE, KS_INIT, KS_MIX, ENC_PRE, ENC_RND, DEC_RND, DEC_POST, DONE.
- IDLE priority, evaluated each edge in this order:
  - key_load=1 → KS_INIT, and key_valid clears.
  - Else encrypt&decrypt both 1 → illegal_req pulse, stay IDLE.
  - Else encrypt or decrypt with key_valid=0 → illegal_req pulse, stay IDLE.
  - Else encrypt → ENC_PRE.
  - Else decrypt → DEC_RND.
- KS_INIT lasts T cycles. ks_init=1; s_addr = 0..T-1.
- KS_MIX lasts M = 3*max(T, KEY_WORDS) = 78 cycles, with k = 0..M-1:
  - ks_mix=1.
  - s_addr = k mod T; l_addr = k mod KEY_WORDS.
  - Both indices are wrap counters, with no divider.
  - On exit, key_valid is set and the machine returns to IDLE. No done pulse.
- ENC_PRE lasts 1 cycle with pre_whiten=1. It is followed by ENC_RND.
- ENC_RND lasts ROUNDS cycles: rnd_en=1, rnd_dir=0, rnd_idx = 1..ROUNDS ascending, s_addr = 2*rnd_idx. Next state is DONE.
- DEC_RND lasts ROUNDS cycles: rnd_en=1, rnd_dir=1, rnd_idx = ROUNDS..1 descending, s_addr = 2*rnd_idx. Next state is DEC_POST.
- DEC_POST lasts 1 cycle with post_whiten=1. Next state is DONE.
- DONE lasts 1 cycle with done=1, then returns to IDLE.
- Requests outside IDLE are ignored: no queueing, no illegal_req. This includes key_load.
- Outside their active states, s_addr, l_addr and rnd_idx are 0, and rnd_dir is 0.

## Timing
- Reset: the state becomes IDLE on the first edge with rst=1. After that edge:
  - ready=1, busy=0.
  - All other outputs are 0, including key_valid.
  - All counters are 0.
- rst overrides everything, including mid key expansion or mid round. An aborted key expansion leaves key_valid=0.
- The request edge is E0.
- Key expansion: cycles E0+1 .. E0+T are KS_INIT, and E0+T+1 .. E0+T+M are KS_MIX. key_valid=1 and ready=1 from E0+T+M+1, which is cycle 105 with the defaults.
- Encrypt: cycle 1 is ENC_PRE, cycles 2..13 are rounds, and done=1 in cycle 14. ready=1 in cycle 15, and a new request can be sampled on that edge.
- Decrypt: cycles 1..12 are rounds, cycle 13 is DEC_POST, and done=1 in cycle 14.
- Op latency is ROUNDS+2 cycles for both directions. Back-to-back throughput is one block per ROUNDS+3 cycles.
- illegal_req is high for exactly the cycle after the offending edge.

## Test plan
- Reset: hold rst=1 for 2 cycles with encrypt=1 → after release, ready=1, key_valid=0, done=0, and no op starts until encrypt is sampled in IDLE.
- Key expansion: pulse key_load → ks_init for 26 cycles with s_addr 0..25; then ks_mix for 78 cycles with s_addr wrapping 25→0 at k=26 and 52, and l_addr wrapping every 8; then key_valid=1 at cycle 105.
- Encrypt after key: pulse encrypt → pre_whiten in cycle 1, rnd_idx 1..12 with s_addr 2..24 and rnd_dir=0, done in cycle 14, ready in cycle 15.
- Decrypt: pulse decrypt → rnd_idx 12..1 with rnd_dir=1, post_whiten in cycle 13, done in cycle 14. Also hold decrypt high continuously → one block per 15 cycles.
- Illegal cases, each giving a one-cycle illegal_req with state staying IDLE:
  - encrypt=decrypt=1.
  - encrypt with key_valid=0.
  - key_load during ENC_RND gives no illegal_req and no effect.
- Simultaneous key_load and encrypt in IDLE → key expansion runs and encrypt is dropped. rst asserted at KS_MIX k=40 → IDLE with key_valid=0; a subsequent encrypt → illegal_req.
